// File: rtl/image_pixel_streamer.sv
// image_pixel_streamer: reads an int8 frame from a synchronous-read memory
// in row-major order, optionally surrounds it with a zero border of PAD
// pixels, and emits one pixel per clock on a valid-only stream that the
// consumer can stall. A one-entry skid keeps the read in flight during a
// stall from being lost.
module image_pixel_streamer #(
  parameter int IMG_W  = 96,
  parameter int IMG_H  = 96,
  parameter int PAD    = 0,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stall_in,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              valid_out,
  output logic [7:0]        pixel_out,
  output logic              busy,
  output logic              done
);

  localparam int OW      = IMG_W + 2 * PAD;
  localparam int OH      = IMG_H + 2 * PAD;
  localparam int MAX_DIM = (OW > OH) ? OW : OH;
  localparam int CNT_W   = $clog2(MAX_DIM) + 1;

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(OW - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(OH - 1);
  localparam logic [CNT_W-1:0] PAD_C    = CNT_W'(PAD);
  localparam logic [CNT_W-1:0] IMG_W_C  = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] IMG_H_C  = CNT_W'(IMG_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  col_reg;
  logic [CNT_W-1:0]  row_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic              busy_reg;
  logic              done_reg;

  // Position issued last cycle: its memory data (or pad) is on mem_rdata now.
  logic              pend_valid_reg;
  logic              pend_pad_reg;

  // One-entry skid for data that returns while the consumer is stalled.
  logic              skid_valid_reg;
  logic              skid_pad_reg;
  logic [7:0]        skid_data_reg;

  // Output register feeding the stream.
  logic              out_valid_reg;
  logic [7:0]        out_data_reg;

  logic [CNT_W-1:0]  col_off;
  logic [CNT_W-1:0]  row_off;
  logic              interior;
  logic              issue;
  logic              rd_fire;
  logic              last_pos;
  logic              last_consumed;
  logic [7:0]        ret_pixel;
  logic [7:0]        skid_pixel;

  // Offsets wrap to large values above the top/left border, so a single
  // unsigned compare per axis classifies the position as interior or pad.
  assign col_off  = col_reg - PAD_C;
  assign row_off  = row_reg - PAD_C;
  assign interior = (col_off < IMG_W_C) && (row_off < IMG_H_C);

  assign issue    = (state_reg == S_RUN) && !stall_in;
  assign rd_fire  = issue && interior;
  assign last_pos = (col_reg == COL_LAST) && (row_reg == ROW_LAST);

  // Nothing in flight or in the skid, and the held pixel is consumed now.
  assign last_consumed = (state_reg == S_DRAIN) && out_valid_reg && !stall_in &&
                         !pend_valid_reg && !skid_valid_reg;

  assign ret_pixel  = pend_pad_reg ? 8'd0 : mem_rdata;
  assign skid_pixel = skid_pad_reg ? 8'd0 : skid_data_reg;

  // Interior pixels are contiguous in memory, so the read address is just a
  // running pointer from base_addr that advances on every read.
  assign mem_rd_en = rd_fire;
  assign mem_addr  = rd_fire ? rd_addr_reg : '0;
  assign valid_out = out_valid_reg && !stall_in;
  assign pixel_out = out_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  // Frame sequencing: scan counters, read pointer, busy and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      col_reg     <= '0;
      row_reg     <= '0;
      rd_addr_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // A start coinciding with the done pulse is deliberately ignored.
          if (start && !done_reg) begin
            state_reg   <= S_RUN;
            busy_reg    <= 1'b1;
            rd_addr_reg <= base_addr;
            col_reg     <= '0;
            row_reg     <= '0;
          end
        end
        S_RUN: begin
          if (!stall_in) begin
            if (interior) begin
              rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
            end
            if (last_pos) begin
              state_reg <= S_DRAIN;
            end else if (col_reg == COL_LAST) begin
              col_reg <= '0;
              row_reg <= row_reg + CNT_W'(1);
            end else begin
              col_reg <= col_reg + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (last_consumed) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Return path: in-flight tracking, skid capture during stalls, output load.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_reg <= 1'b0;
      pend_pad_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_pad_reg   <= 1'b0;
      skid_data_reg  <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
    end else begin
      pend_valid_reg <= issue;
      pend_pad_reg   <= !interior;
      if (stall_in) begin
        // Issue is blocked while stalled, so at most one return lands here.
        if (pend_valid_reg) begin
          skid_valid_reg <= 1'b1;
          skid_pad_reg   <= pend_pad_reg;
          skid_data_reg  <= mem_rdata;
        end
      end else begin
        skid_valid_reg <= 1'b0;
        // The skid is older than anything returning now, so it goes first.
        if (skid_valid_reg) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= skid_pixel;
        end else if (pend_valid_reg) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= ret_pixel;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Bench for image_pixel_streamer: two 4x4 instances (PAD=0 and PAD=1) with
// synchronous-read memory models, a per-cycle vector table for the plain
// stream, and sequences for padding, stalls, ignored starts and reset.
module tb_image_pixel_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [15:0] base_addr;

  logic        start0, rd_en0, valid0, busy0, done0;
  logic [15:0] addr0;
  logic [7:0]  rdata0, pixel0;
  logic        start1, rd_en1, valid1, busy1, done1;
  logic [15:0] addr1;
  logic [7:0]  rdata1, pixel1;

  int checks = 0;
  int errors = 0;
  bit sel    = 1'b0;

  always #5 clk = ~clk;

  image_pixel_streamer #(.IMG_W(4), .IMG_H(4), .PAD(0), .ADDR_W(16)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .base_addr(base_addr),
    .stall_in(stall), .mem_rd_en(rd_en0), .mem_addr(addr0),
    .mem_rdata(rdata0), .valid_out(valid0), .pixel_out(pixel0),
    .busy(busy0), .done(done0)
  );

  image_pixel_streamer #(.IMG_W(4), .IMG_H(4), .PAD(1), .ADDR_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .base_addr(base_addr),
    .stall_in(stall), .mem_rd_en(rd_en1), .mem_addr(addr1),
    .mem_rdata(rdata1), .valid_out(valid1), .pixel_out(pixel1),
    .busy(busy1), .done(done1)
  );

  // Memories: dut0 sees mem[a]=a, dut1 sees mem[a]=a+1; 0xAA when not read.
  always @(posedge clk) begin
    rdata0 <= rd_en0 ? addr0[7:0] : 8'hAA;
    rdata1 <= rd_en1 ? (addr1[7:0] + 8'd1) : 8'hAA;
  end

  logic        m_valid, m_rd_en, m_busy, m_done;
  logic [7:0]  m_pixel;
  logic [15:0] m_addr;
  assign m_valid = sel ? valid1 : valid0;
  assign m_rd_en = sel ? rd_en1 : rd_en0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;
  assign m_pixel = sel ? pixel1 : pixel0;
  assign m_addr  = sel ? addr1  : addr0;

  typedef struct {
    bit stall;
    bit rd_en;
    int addr;
    bit valid;
    int pixel;
    bit busy;
    bit done;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_start(input bit s, input bit v);
    if (s) start1 = v;
    else   start0 = v;
  endtask

  // Expected k-th consumed pixel of a frame.
  function automatic int exp_pix(input bit s, input int b, input int i);
    int r, c;
    if (!s) return (b + i) % 256;
    r = i / 6;
    c = i % 6;
    if (r >= 1 && r <= 4 && c >= 1 && c <= 4) return (r - 1) * 4 + (c - 1) + 1;
    return 0;
  endfunction

  // Runs one full frame on the selected instance and checks the stream.
  task automatic run_frame(input bit s, input int b, input bit stall_mode,
                           input bit poke_start);
    int  k, nval, nrd, last_vk, exp_v;
    bit  seen_done;
    sel       = s;
    exp_v     = s ? 36 : 16;
    base_addr = 16'(b);
    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
    base_addr = 16'hFFFF;
    k = 1; nval = 0; nrd = 0; last_vk = -10; seen_done = 1'b0;
    while (!seen_done && k < 300) begin
      stall = stall_mode && ((k >= 3 && k <= 5) || (k > 5 && (k % 2) == 0));
      set_start(s, poke_start && (k == 5));
      #1;
      if (stall) check("valid_during_stall", int'(m_valid), 0);
      if (m_valid) begin
        check($sformatf("pixel[%0d]", nval), int'(m_pixel), exp_pix(s, b, nval));
        nval++;
        last_vk = k;
      end
      if (m_rd_en) begin
        check($sformatf("addr[%0d]", nrd), int'(m_addr), b + nrd);
        nrd++;
      end
      check("busy", int'(m_busy), m_done ? 0 : 1);
      if (m_done) begin
        seen_done = 1'b1;
        check("valid_count", nval, exp_v);
        check("read_count", nrd, 16);
        check("done_after_last_valid", k - last_vk, 1);
        if (poke_start) set_start(s, 1'b1);
      end
      tick();
      k++;
    end
    set_start(s, 1'b0);
    stall = 1'b0;
    if (!seen_done) check("frame_timeout", 0, 1);
    if (poke_start) begin
      #1;
      check("start_in_done_busy", int'(m_busy), 0);
      check("start_in_done_rd_en", int'(m_rd_en), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    reset = 1'b1; stall = 1'b0; start0 = 1'b0; start1 = 1'b0; base_addr = '0;

    // Plain 4x4 stream: cycle k counts from the first cycle after start.
    for (int k = 1; k <= 20; k++) begin
      tbl[k-1].stall = 1'b0;
      tbl[k-1].rd_en = (k <= 16);
      tbl[k-1].addr  = (k <= 16) ? k - 1 : 0;
      tbl[k-1].valid = (k >= 3 && k <= 18);
      tbl[k-1].pixel = k - 3;
      tbl[k-1].busy  = (k <= 18);
      tbl[k-1].done  = (k == 19);
    end

    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("reset_rd_en0", int'(rd_en0), 0);
    check("reset_addr0", int'(addr0), 0);
    check("reset_valid0", int'(valid0), 0);
    check("reset_pixel0", int'(pixel0), 0);
    check("reset_busy0", int'(busy0), 0);
    check("reset_done0", int'(done0), 0);
    check("reset_busy1", int'(busy1), 0);
    check("reset_valid1", int'(valid1), 0);
    tick();

    // Idle stall has no effect.
    stall = 1'b1;
    #1;
    check("idle_stall_busy", int'(busy0), 0);
    tick();
    stall = 1'b0;

    // Table-driven per-cycle vectors.
    sel = 1'b0;
    base_addr = 16'd0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      stall = tbl[i].stall;
      #1;
      check($sformatf("t%0d_rd_en", i + 1), int'(rd_en0), int'(tbl[i].rd_en));
      check($sformatf("t%0d_addr", i + 1), int'(addr0), tbl[i].addr);
      check($sformatf("t%0d_valid", i + 1), int'(valid0), int'(tbl[i].valid));
      if (tbl[i].valid)
        check($sformatf("t%0d_pixel", i + 1), int'(pixel0), tbl[i].pixel);
      check($sformatf("t%0d_busy", i + 1), int'(busy0), int'(tbl[i].busy));
      check($sformatf("t%0d_done", i + 1), int'(done0), int'(tbl[i].done));
      tick();
    end

    // PAD=1 frame with zero border.
    run_frame(1'b1, 0, 1'b0, 1'b0);
    tick();
    // Stalls at cycles 3-5, then every other cycle.
    run_frame(1'b0, 0, 1'b1, 1'b0);
    tick();
    // Padded frame under the same stall pattern.
    run_frame(1'b1, 0, 1'b1, 1'b0);
    tick();
    // Starts during RUN and in the done cycle are ignored; then a fresh
    // frame at base 100 starts one cycle after done.
    run_frame(1'b0, 0, 1'b0, 1'b1);
    run_frame(1'b0, 100, 1'b0, 1'b0);
    tick();

    // Reset in the cycle pixel 7 is consumed.
    sel = 1'b0;
    base_addr = 16'd0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    nv = 0;
    for (int k = 0; k < 50 && nv < 8; k++) begin
      #1;
      if (valid0) nv++;
      if (nv < 8) tick();
    end
    check("reset_mid_reached_px7", nv, 8);
    reset = 1'b1;
    tick();
    #1;
    check("rst_mid_busy", int'(busy0), 0);
    check("rst_mid_valid", int'(valid0), 0);
    check("rst_mid_rd_en", int'(rd_en0), 0);
    check("rst_mid_done", int'(done0), 0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      check("rst_after_done", int'(done0), 0);
      check("rst_after_valid", int'(valid0), 0);
    end
    tick();
    run_frame(1'b0, 0, 1'b1, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_pixel_streamer.md
Name: image_pixel_streamer

Overview:
- Upstream feeder for the 4x4 sliding-window stage.
- Reads one int8 image frame from a synchronous-read on-chip memory in row-major order and emits one pixel per clock on a valid-only stream.
- Optionally inserts a zero-pad border of PAD pixels on every side.
- Supports a consumer/arbiter stall without dropping or duplicating pixels, and reports frame start/busy/done to the layer controller.

Parameters:
- IMG_W, 96, stored image width in pixels.
- IMG_H, 96, stored image height in pixels.
- PAD, 0, zero-pad border width per side; legal values 0..3.
- ADDR_W, 16, memory address width; must satisfy 2^ADDR_W >= base_addr + IMG_W*IMG_H.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only when busy=0.
- base_addr  in  ADDR_W  frame base address; sampled with an accepted start.
- stall_in  in  1  1 = hold the stream this cycle.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  8  int8_t read data; valid exactly 1 cycle after mem_rd_en.
- valid_out  out  1  pixel_out is valid and consumed this cycle.
- pixel_out  out  8  int8_t pixel; feeds the sliding window's pixel_in.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset values: mem_rd_en=0, mem_addr=0, valid_out=0, pixel_out=0, busy=0, done=0. All counters and the skid entry are cleared.
- Output frame is OW x OH, where OW=IMG_W+2*PAD and OH=IMG_H+2*PAD. Scan is row-major; col counter wraps OW-1 -> 0 and increments row.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start=1. busy=1 from the next cycle. base_addr is latched and col=row=0.
- start while busy=1 is ignored, with no effect.
- RUN, issue:
  - A position is issued in every cycle with stall_in=0. No issue occurs in a stall cycle; counters hold.
  - Interior position (PAD <= row < PAD+IMG_H and PAD <= col < PAD+IMG_W): mem_rd_en=1, mem_addr = base + (row-PAD)*IMG_W + (col-PAD).
  - Pad position: mem_rd_en=0, and the pixel value is forced to 0.
- Address arithmetic is unsigned, ADDR_W bits, with no wrap checking.
- Latency: a position issued in cycle t appears on pixel_out in cycle t+2, provided stall_in=0 in t+1 and t+2.
- Output register:
  - Advances only when stall_in=0.
  - valid_out = out_valid_reg AND NOT stall_in (combinational gating), so the sliding window sees valid only in cycles where the pixel is actually consumed.
  - While stalled, pixel_out holds its value.
- Skid:
  - Read data returning during a stall cycle is captured into a 1-entry skid register, together with its pad flag.
  - On un-stall, the skid entry drains first, in order.
  - One entry suffices because issue stops in stall cycles. Loss or duplication of any pixel is a bug.
- RUN -> DRAIN after the last position (row=OH-1, col=OW-1) is issued.
- DRAIN: no issue. Wait until the last pixel is consumed, i.e. valid_out=1 for it.
- done pulses 1 cycle in the cycle after the last pixel's valid_out=1. busy drops with done, and the state returns to IDLE. A new start in the done cycle is ignored; it is accepted from the following cycle.
- Exactly OW*OH valid_out pulses and IMG_W*IMG_H mem_rd_en pulses occur per frame.
- stall_in is permitted in any state; in IDLE it has no effect.
- reset mid-frame: all outputs return to reset values the next cycle. The in-flight read is discarded and no done is issued.
- PAD=0: no pad positions exist; the behaviour is a pure memory stream.

Test Plan:
- IMG_W=IMG_H=4, PAD=0, base=0, memory[i]=i, no stall:
  - mem_addr sequence is 0..15 on consecutive cycles starting 1 cycle after start.
  - pixel_out sequence 0..15 with valid_out asserted continuously, first valid 3 cycles after start.
  - done is 1 cycle after the last valid; exactly 16 valids.
- IMG_W=IMG_H=4, PAD=1, memory[i]=i+1:
  - 36 valids.
  - Row 0, row 5, col 0 and col 5 are all 0.
  - The interior reads 1..16 row-major.
  - mem_rd_en pulses exactly 16 times.
- Same as scenario 1 with stall_in=1 for cycles 3-5 and on every other cycle thereafter:
  - Consumed pixel sequence (valid_out=1 cycles) is still exactly 0..15.
  - valid_out=0 whenever stall_in=1.
  - No duplicates; done follows the 16th consumed pixel.
- start re-asserted during RUN and in the done cycle:
  - Both are ignored, with no address restart.
  - A start 1 cycle after done begins a fresh frame from base_addr.
- base_addr=100, IMG 4x4, PAD=0: mem_addr sequence is 100..115.
- reset asserted at pixel 7 of a 4x4 frame:
  - Next cycle: busy=0, valid_out=0, mem_rd_en=0, and no done pulse.
  - A subsequent start streams the full 16 pixels correctly.
